// File: rtl/helm_msg_xmt.sv
// -----------------------------------------------------------------------------
// helm_msg_xmt
//   Transmit-side framer for the helm UART message link. One msg_start request
//   produces one frame on the tx byte stream:
//     preamble(4B) | type | seq_no | length | data[N] | checksum
//   N = length, except that a length of 0 still carries one data byte.
//   Payload bytes are fetched from an external message buffer: each byte costs
//   a FETCH cycle (read strobe + address, no byte offered) followed by the
//   DATA cycle in which the fetched byte is offered.
//   Checksum = 8-bit wrapping sum of type, seq_no, length and all data bytes.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   msg_start         1-cycle request, honoured only while idle
//   msg_type          message type, captured on start
//   msg_seq_no        sequence number, captured on start
//   msg_data_length   length field, captured on start
//   msg_data_adr      payload buffer read address (0..N-1)
//   msg_data_rd       payload buffer read strobe
//   msg_data          payload byte returned by the buffer
//   tx_data, tx_vld   byte offered to the UART TX, held until accepted
//   tx_rdy            UART TX accepts the byte when tx_vld & tx_rdy
//   msg_busy          high from start capture until the checksum is accepted
//   msg_done          1-cycle pulse after the checksum is accepted
// -----------------------------------------------------------------------------
module helm_msg_xmt #(
  parameter logic [31:0] PREAMBLE = 32'hAA995566
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       msg_start,
  input  logic [7:0] msg_type,
  input  logic [7:0] msg_seq_no,
  input  logic [7:0] msg_data_length,
  output logic [7:0] msg_data_adr,
  output logic       msg_data_rd,
  input  logic [7:0] msg_data,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  input  logic       tx_rdy,
  output logic       msg_busy,
  output logic       msg_done
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_PRE0  = 4'd1,
    S_PRE1  = 4'd2,
    S_PRE2  = 4'd3,
    S_PRE3  = 4'd4,
    S_TYPE  = 4'd5,
    S_SEQ   = 4'd6,
    S_LEN   = 4'd7,
    S_FETCH = 4'd8,
    S_DATA  = 4'd9,
    S_CHK   = 4'd10
  } state_t;

  state_t     state_q;
  logic [7:0] type_q;
  logic [7:0] seq_q;
  logic [7:0] len_q;
  logic [7:0] cnt_q;      // data bytes still to send, including the current one
  logic [7:0] adr_q;
  logic [7:0] chksum_q;
  logic [7:0] tx_data_q;
  logic       tx_vld_q;
  logic       rd_q;
  logic       busy_q;
  logic       done_q;
  logic       tx_accept;

  // Wrapping 8-bit checksum accumulate.
  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  assign tx_accept = tx_vld_q & tx_rdy;

  // Frame sequencer; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      type_q    <= 8'd0;
      seq_q     <= 8'd0;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      adr_q     <= 8'd0;
      chksum_q  <= 8'd0;
      tx_data_q <= 8'd0;
      tx_vld_q  <= 1'b0;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (msg_start) begin
            type_q    <= msg_type;
            seq_q     <= msg_seq_no;
            len_q     <= msg_data_length;
            cnt_q     <= (msg_data_length == 8'd0) ? 8'd1 : msg_data_length;
            adr_q     <= 8'd0;
            chksum_q  <= 8'd0;
            busy_q    <= 1'b1;
            tx_data_q <= PREAMBLE[31:24];
            tx_vld_q  <= 1'b1;
            state_q   <= S_PRE0;
          end
        end
        S_PRE0: begin
          if (tx_accept) begin
            tx_data_q <= PREAMBLE[23:16];
            state_q   <= S_PRE1;
          end
        end
        S_PRE1: begin
          if (tx_accept) begin
            tx_data_q <= PREAMBLE[15:8];
            state_q   <= S_PRE2;
          end
        end
        S_PRE2: begin
          if (tx_accept) begin
            tx_data_q <= PREAMBLE[7:0];
            state_q   <= S_PRE3;
          end
        end
        S_PRE3: begin
          if (tx_accept) begin
            tx_data_q <= type_q;
            state_q   <= S_TYPE;
          end
        end
        S_TYPE: begin
          if (tx_accept) begin
            chksum_q  <= chk_add(chksum_q, tx_data_q);
            tx_data_q <= seq_q;
            state_q   <= S_SEQ;
          end
        end
        S_SEQ: begin
          if (tx_accept) begin
            chksum_q  <= chk_add(chksum_q, tx_data_q);
            tx_data_q <= len_q;
            state_q   <= S_LEN;
          end
        end
        S_LEN: begin
          if (tx_accept) begin
            chksum_q <= chk_add(chksum_q, tx_data_q);
            tx_vld_q <= 1'b0;
            rd_q     <= 1'b1;
            state_q  <= S_FETCH;
          end
        end
        // Read strobe is high for this cycle only; the buffer byte is taken
        // at the end of it and offered in DATA.
        S_FETCH: begin
          rd_q      <= 1'b0;
          tx_data_q <= msg_data;
          tx_vld_q  <= 1'b1;
          state_q   <= S_DATA;
        end
        S_DATA: begin
          if (tx_accept) begin
            chksum_q <= chk_add(chksum_q, tx_data_q);
            cnt_q    <= cnt_q - 8'd1;
            adr_q    <= adr_q + 8'd1;
            if (cnt_q == 8'd1) begin
              // Last data byte: checksum goes out straight away.
              tx_data_q <= chk_add(chksum_q, tx_data_q);
              state_q   <= S_CHK;
            end else begin
              tx_vld_q <= 1'b0;
              rd_q     <= 1'b1;
              state_q  <= S_FETCH;
            end
          end
        end
        S_CHK: begin
          if (tx_accept) begin
            tx_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          tx_vld_q <= 1'b0;
          rd_q     <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign msg_data_adr = adr_q;
  assign msg_data_rd  = rd_q;
  assign tx_data      = tx_data_q;
  assign tx_vld       = tx_vld_q;
  assign msg_busy     = busy_q;
  assign msg_done     = done_q;

endmodule
